// File: rtl/vga_framebuffer_db_if.sv
// vga_framebuffer_db_if
//   Pixel write channel from the drawing logic into the framebuffer.
//   Signals:
//     wr_x, wr_y  target column / row
//     wr_data     pixel value (PIXEL_W bits)
//     wr_valid    drawer has a write this cycle
//     wr_ready    framebuffer can take a write this cycle
//     wr_drop     one-cycle pulse after an accepted write that was off-screen
//   Handshake: a write transfers on every CLOCK_50 edge where wr_valid and
//   wr_ready are both 1. Nothing is buffered, so the drawer keeps wr_x, wr_y,
//   wr_data and wr_valid stable until it sees that edge. wr_ready does not
//   depend on wr_valid.
interface vga_framebuffer_db_if #(
    parameter int PIXEL_W = 8
);
    logic [10:0]        wr_x;
    logic [10:0]        wr_y;
    logic [PIXEL_W-1:0] wr_data;
    logic               wr_valid;
    logic               wr_ready;
    logic               wr_drop;

    modport master (
        output wr_x, wr_y, wr_data, wr_valid,
        input  wr_ready, wr_drop
    );

    modport slave (
        input  wr_x, wr_y, wr_data, wr_valid,
        output wr_ready, wr_drop
    );
endinterface

// File: rtl/vga_framebuffer_db.sv
// vga_framebuffer_db
//   Double-buffered VGA framebuffer. The drawer writes into the back bank
//   while the front bank is streamed to the DAC; a requested swap takes effect
//   only at the end of the last visible line, so a frame never tears.
//   Ports:
//     CLOCK_50, reset_n      system clock, synchronous active-low reset
//     wr (slave)             pixel write channel, see vga_framebuffer_db_if
//     swap_req / swap_ack    swap request / one-cycle pulse when banks swap
//     front_sel              bank currently displayed
//     frame_start            one-cycle pulse when the raster wraps to (0,0)
//     VGA_R/G/B, VGA_X/Y     pixel colour and its coordinates, aligned
//     VGA_CLK, VGA_HS/VS     pixel clock and active-low syncs
//     VGA_BLANK_N, VGA_SYNC_N
module vga_framebuffer_db #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int PIXEL_W    = 8,
    parameter int COLOR_MODE = 0
) (
    input  logic                 CLOCK_50,
    input  logic                 reset_n,
    vga_framebuffer_db_if.slave  wr,
    input  logic                 swap_req,
    output logic                 swap_ack,
    output logic                 front_sel,
    output logic                 frame_start,
    output logic [7:0]           VGA_R,
    output logic [7:0]           VGA_G,
    output logic [7:0]           VGA_B,
    output logic [9:0]           VGA_X,
    output logic [9:0]           VGA_Y,
    output logic                 VGA_CLK,
    output logic                 VGA_HS,
    output logic                 VGA_VS,
    output logic                 VGA_BLANK_N,
    output logic                 VGA_SYNC_N
);
    localparam int HTOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VTOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DEPTH = H_ACTIVE * V_ACTIVE;
    localparam int HW    = $clog2(HTOT);
    localparam int VW    = $clog2(VTOT);
    localparam int AW    = $clog2(DEPTH);

    logic [PIXEL_W-1:0] bank0_mem [DEPTH];
    logic [PIXEL_W-1:0] bank1_mem [DEPTH];

    // Raster / control state
    logic          pix_en_q, pix_en_d;
    logic [HW-1:0] hcount_q, hcount_d;
    logic [VW-1:0] vcount_q, vcount_d;
    logic          front_sel_q, front_sel_d;
    logic          pend_q, pend_d;
    logic          swap_ack_q, swap_ack_d;
    logic          wr_drop_q, wr_drop_d;
    logic          frame_start_q, frame_start_d;
    // Stage 1: RAM read data plus timing delayed alongside it
    logic [PIXEL_W-1:0] rd_q, rd_d;
    logic          s1_blank_q, s1_blank_d, s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d;
    logic [9:0]    s1_x_q, s1_x_d, s1_y_q, s1_y_d;
    // Stage 2: pins
    logic [7:0]    r_q, r_d, g_q, g_d, b_q, b_d;
    logic          blank_q, blank_d, hs_q, hs_d, vs_q, vs_d;
    logic [9:0]    x_q, x_d, y_q, y_d;

    logic          h_last, active, swap_pt, do_swap;
    logic          wr_accept, wr_in_range;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [7:0]    p8, col_r, col_g, col_b;

    always_comb begin
        h_last   = (hcount_q == HW'(HTOT - 1));
        active   = (int'(hcount_q) < H_ACTIVE) && (int'(vcount_q) < V_ACTIVE);
        pix_en_d = ~pix_en_q;
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (pix_en_q) begin
            if (h_last) begin
                hcount_d = '0;
                vcount_d = (vcount_q == VW'(VTOT - 1)) ? '0 : vcount_q + VW'(1);
            end else begin
                hcount_d = hcount_q + HW'(1);
            end
        end
        frame_start_d = pix_en_q && h_last && (vcount_q == VW'(VTOT - 1));

        // A request arriving on the swap point itself still makes this frame.
        swap_pt     = pix_en_q && h_last && (vcount_q == VW'(V_ACTIVE - 1));
        do_swap     = swap_pt && (pend_q || swap_req);
        front_sel_d = front_sel_q ^ do_swap;
        pend_d      = do_swap ? 1'b0 : (pend_q || swap_req);
        swap_ack_d  = do_swap;

        wr_accept   = wr.wr_valid && !swap_ack_q;
        wr_in_range = (int'(wr.wr_x) < H_ACTIVE) && (int'(wr.wr_y) < V_ACTIVE);
        wr_addr     = AW'(int'(wr.wr_y) * H_ACTIVE + int'(wr.wr_x));
        wr_drop_d   = wr_accept && !wr_in_range;

        // Off-screen positions read address 0; the data is blanked anyway.
        rd_addr    = active ? AW'(int'(vcount_q) * H_ACTIVE + int'(hcount_q)) : '0;
        rd_d       = front_sel_q ? bank1_mem[rd_addr] : bank0_mem[rd_addr];
        s1_blank_d = active;
        s1_hs_d    = !((int'(hcount_q) >= H_ACTIVE + H_FP) &&
                       (int'(hcount_q) <  H_ACTIVE + H_FP + H_SYNC));
        s1_vs_d    = !((int'(vcount_q) >= V_ACTIVE + V_FP) &&
                       (int'(vcount_q) <  V_ACTIVE + V_FP + V_SYNC));
        s1_x_d     = 10'(hcount_q);
        s1_y_d     = 10'(vcount_q);

        // MSB-align the stored pixel into 8 bits, refilling low bits with
        // the pixel's own MSBs (identity when PIXEL_W == 8).
        p8 = '0;
        for (int i = 0; i < 8; i++) begin
            p8[7 - i] = rd_q[PIXEL_W - 1 - (i % PIXEL_W)];
        end
        if (COLOR_MODE == 1) begin
            col_r = {p8[7:5], p8[7:5], p8[7:6]};
            col_g = {p8[4:2], p8[4:2], p8[4:3]};
            col_b = {p8[1:0], p8[1:0], p8[1:0], p8[1:0]};
        end else begin
            col_r = p8;
            col_g = p8;
            col_b = p8;
        end
        r_d     = s1_blank_q ? col_r : 8'h00;
        g_d     = s1_blank_q ? col_g : 8'h00;
        b_d     = s1_blank_q ? col_b : 8'h00;
        blank_d = s1_blank_q;
        hs_d    = s1_hs_q;
        vs_d    = s1_vs_q;
        x_d     = s1_x_q;
        y_d     = s1_y_q;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            pix_en_q      <= 1'b0;
            hcount_q      <= '0;
            vcount_q      <= '0;
            front_sel_q   <= 1'b0;
            pend_q        <= 1'b0;
            swap_ack_q    <= 1'b0;
            wr_drop_q     <= 1'b0;
            frame_start_q <= 1'b0;
            rd_q          <= '0;
            s1_blank_q    <= 1'b0;
            s1_hs_q       <= 1'b1;
            s1_vs_q       <= 1'b1;
            s1_x_q        <= '0;
            s1_y_q        <= '0;
            r_q           <= '0;
            g_q           <= '0;
            b_q           <= '0;
            blank_q       <= 1'b0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            x_q           <= '0;
            y_q           <= '0;
        end else begin
            pix_en_q      <= pix_en_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            front_sel_q   <= front_sel_d;
            pend_q        <= pend_d;
            swap_ack_q    <= swap_ack_d;
            wr_drop_q     <= wr_drop_d;
            frame_start_q <= frame_start_d;
            rd_q          <= rd_d;
            s1_blank_q    <= s1_blank_d;
            s1_hs_q       <= s1_hs_d;
            s1_vs_q       <= s1_vs_d;
            s1_x_q        <= s1_x_d;
            s1_y_q        <= s1_y_d;
            r_q           <= r_d;
            g_q           <= g_d;
            b_q           <= b_d;
            blank_q       <= blank_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            x_q           <= x_d;
            y_q           <= y_d;
        end
    end

    // Bank storage is deliberately not reset. Writes always target the bank
    // that is not on screen during the cycle of the write.
    always_ff @(posedge CLOCK_50) begin
        if (wr_accept && wr_in_range) begin
            if (!front_sel_q) bank1_mem[wr_addr] <= wr.wr_data;
            else              bank0_mem[wr_addr] <= wr.wr_data;
        end
    end

    // wr_ready drops only on the cycle the new front_sel first applies.
    assign wr.wr_ready  = ~swap_ack_q;
    assign wr.wr_drop   = wr_drop_q;
    assign swap_ack     = swap_ack_q;
    assign front_sel    = front_sel_q;
    assign frame_start  = frame_start_q;
    assign VGA_R        = r_q;
    assign VGA_G        = g_q;
    assign VGA_B        = b_q;
    assign VGA_X        = x_q;
    assign VGA_Y        = y_q;
    assign VGA_CLK      = pix_en_q;
    assign VGA_HS       = hs_q;
    assign VGA_VS       = vs_q;
    assign VGA_BLANK_N  = blank_q;
    assign VGA_SYNC_N   = 1'b1;
endmodule

// File: tb/tb_vga_framebuffer_db.sv
// Bench for vga_framebuffer_db on a shrunken raster (23 x 13 pixel periods).
// dut_a: 8-bit pixels, RGB332.  dut_b: 5-bit pixels, greyscale.
// Both get identical stimulus; a cycle-indexed reference model predicts every
// output, with pin values queued two cycles ahead.
module tb_vga_framebuffer_db;
  localparam int HA = 16, HF = 2, HSW = 3, HB = 2;
  localparam int VA = 8,  VF = 1, VSW = 2, VB = 2;
  localparam int HTOT  = HA + HF + HSW + HB;
  localparam int VTOT  = VA + VF + VSW + VB;
  localparam int FRAME = HTOT * VTOT * 2;
  localparam int DEPTH = HA * VA;
  // cycle offset (within a frame) of the swap point: last pixel of line VA-1, pix_en=1
  localparam int SWAP_OFF = 2 * (HTOT * VA - 1) + 1;

  typedef struct packed {
    logic       chk;
    logic [7:0] ra, ga, ba, gb;
    logic [9:0] x, y;
    logic       hs, vs, bn;
  } pins_t;
  localparam int PW = $bits(pins_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic swap_req;
  vga_framebuffer_db_if #(.PIXEL_W(8)) bus_a ();
  vga_framebuffer_db_if #(.PIXEL_W(5)) bus_b ();

  logic swap_ack_a, front_sel_a, frame_start_a, clk_a, hs_a, vs_a, bn_a, sn_a;
  logic swap_ack_b, front_sel_b, frame_start_b, clk_b, hs_b, vs_b, bn_b, sn_b;
  logic [7:0] r_a, g_a, b_a, r_b, g_b, b_b;
  logic [9:0] x_a, y_a, x_b, y_b;

  vga_framebuffer_db #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB), .PIXEL_W(8), .COLOR_MODE(1)) dut_a (
    .CLOCK_50(clk), .reset_n(reset_n), .wr(bus_a.slave), .swap_req(swap_req),
    .swap_ack(swap_ack_a), .front_sel(front_sel_a), .frame_start(frame_start_a),
    .VGA_R(r_a), .VGA_G(g_a), .VGA_B(b_a), .VGA_X(x_a), .VGA_Y(y_a),
    .VGA_CLK(clk_a), .VGA_HS(hs_a), .VGA_VS(vs_a), .VGA_BLANK_N(bn_a), .VGA_SYNC_N(sn_a));

  vga_framebuffer_db #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB), .PIXEL_W(5), .COLOR_MODE(0)) dut_b (
    .CLOCK_50(clk), .reset_n(reset_n), .wr(bus_b.slave), .swap_req(swap_req),
    .swap_ack(swap_ack_b), .front_sel(front_sel_b), .frame_start(frame_start_b),
    .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b), .VGA_X(x_b), .VGA_Y(y_b),
    .VGA_CLK(clk_b), .VGA_HS(hs_b), .VGA_VS(vs_b), .VGA_BLANK_N(bn_b), .VGA_SYNC_N(sn_b));

  // ---------------- scoreboard / model state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int ack_cnt = 0;
  int last_fs = -1;
  logic [PW-1:0] exp_q[$];
  logic [7:0] mem_m [2][DEPTH];
  bit         known [2][DEPTH];
  bit front_m, pend_m, ack_m, drop_m, frame_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] exp_r332(input logic [7:0] p);
    int r3 = int'(p) / 32;
    return 8'(r3 * 32 + r3 * 4 + r3 / 2);
  endfunction
  function automatic logic [7:0] exp_g332(input logic [7:0] p);
    int g3 = (int'(p) / 4) % 8;
    return 8'(g3 * 32 + g3 * 4 + g3 / 2);
  endfunction
  function automatic logic [7:0] exp_b332(input logic [7:0] p);
    return 8'((int'(p) % 4) * 85);
  endfunction
  function automatic logic [7:0] exp_grey5(input logic [7:0] p);
    int p5 = int'(p) % 32;
    return 8'(p5 * 8 + p5 / 4);
  endfunction

  function automatic pins_t reset_pins();
    pins_t e = '0;
    e.chk = 1'b1;
    e.hs  = 1'b1;
    e.vs  = 1'b1;
    return e;
  endfunction

  // ---------------- driver: one CLOCK_50 cycle ----------------
  task automatic step(input bit v, input int x, input int y, input logic [7:0] d, input bit sreq);
    int pos, h, vv, a;
    bit act, inr, acc;
    pins_t e, got;
    logic [7:0] px;
    pos = cyc / 2;
    h   = pos % HTOT;
    vv  = (pos / HTOT) % VTOT;
    act = (h < HA) && (vv < VA);
    e = '0;
    e.chk = 1'b1;
    e.x   = 10'(h);
    e.y   = 10'(vv);
    e.hs  = !((h >= HA + HF) && (h < HA + HF + HSW));
    e.vs  = !((vv >= VA + VF) && (vv < VA + VF + VSW));
    e.bn  = act;
    if (act) begin
      a     = vv * HA + h;
      px    = mem_m[front_m][a];
      e.chk = known[front_m][a];
      e.ra  = exp_r332(px);
      e.ga  = exp_g332(px);
      e.ba  = exp_b332(px);
      e.gb  = exp_grey5(px);
    end
    exp_q.push_back(e);

    got = exp_q.pop_front();
    check("hs", {hs_a, hs_b}, {got.hs, got.hs});
    check("vs", {vs_a, vs_b}, {got.vs, got.vs});
    check("blank_n", {bn_a, bn_b}, {got.bn, got.bn});
    check("xy", {x_a, y_a, x_b, y_b}, {got.x, got.y, got.x, got.y});
    if (got.chk) begin
      check("rgb_a", {r_a, g_a, b_a}, {got.ra, got.ga, got.ba});
      check("rgb_b", {r_b, g_b, b_b}, {got.gb, got.gb, got.gb});
    end
    check("vga_clk", {clk_a, clk_b}, {2{cyc % 2 == 1}});
    check("sync_n", {sn_a, sn_b}, 2'b11);
    check("front_sel", {front_sel_a, front_sel_b}, {front_m, front_m});
    check("swap_ack", {swap_ack_a, swap_ack_b}, {ack_m, ack_m});
    check("wr_ready", {bus_a.wr_ready, bus_b.wr_ready}, {!ack_m, !ack_m});
    check("wr_drop", {bus_a.wr_drop, bus_b.wr_drop}, {drop_m, drop_m});
    check("frame_start", {frame_start_a, frame_start_b}, {frame_m, frame_m});
    if (swap_ack_a) ack_cnt++;
    if (frame_start_a) begin
      if (last_fs >= 0) check("frame_period", cyc - last_fs, FRAME);
      last_fs = cyc;
    end

    bus_a.wr_valid = v;       bus_b.wr_valid = v;
    bus_a.wr_x = 11'(x);      bus_b.wr_x = 11'(x);
    bus_a.wr_y = 11'(y);      bus_b.wr_y = 11'(y);
    bus_a.wr_data = d;        bus_b.wr_data = d[4:0];
    swap_req = sreq;

    // effect of the coming edge
    acc = v && !ack_m;
    inr = (x < HA) && (y < VA);
    if (acc && inr) begin
      mem_m[!front_m][y * HA + x] = d;
      known[!front_m][y * HA + x] = 1'b1;
    end
    drop_m  = acc && !inr;
    frame_m = (cyc % 2 == 1) && (h == HTOT - 1) && (vv == VTOT - 1);
    if ((cyc % 2 == 1) && (h == HTOT - 1) && (vv == VA - 1) && (pend_m || sreq)) begin
      front_m = !front_m;
      pend_m  = 1'b0;
      ack_m   = 1'b1;
    end else begin
      pend_m  = pend_m || sreq;
      ack_m   = 1'b0;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00, 0);
  endtask

  // advance (bounded) until the cycle offset within the frame equals off
  task automatic align(input int off);
    for (int i = 0; i < FRAME && (cyc % FRAME) != off; i++) step(0, 0, 0, 8'h00, 0);
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    bus_a.wr_valid = 1'b0; bus_b.wr_valid = 1'b0;
    swap_req = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("rst_sync", {hs_a, vs_a, bn_a, hs_b, vs_b, bn_b}, 6'b110110);
      check("rst_rgb", {r_a, g_a, b_a, r_b, g_b, b_b}, 48'h0);
      check("rst_ctl", {clk_a, swap_ack_a, bus_a.wr_drop, frame_start_a, front_sel_a, bus_a.wr_ready},
            6'b000001);
      check("rst_ctl_b", {clk_b, swap_ack_b, bus_b.wr_drop, frame_start_b, front_sel_b, bus_b.wr_ready},
            6'b000001);
    end
    reset_n = 1'b1;
    cyc = 0; last_fs = -1;
    front_m = 0; pend_m = 0; ack_m = 0; drop_m = 0; frame_m = 0;
    exp_q.delete();
    exp_q.push_back(reset_pins());
    exp_q.push_back(reset_pins());
  endtask

  task automatic fill_back_bank();
    for (int y = 0; y < VA; y++)
      for (int x = 0; x < HA; x++)
        step(1, x, y, 8'($urandom_range(0, 255)), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int acks0;
    bit fs0;
    bus_a.wr_x = '0; bus_a.wr_y = '0; bus_a.wr_data = '0; bus_a.wr_valid = 1'b0;
    bus_b.wr_x = '0; bus_b.wr_y = '0; bus_b.wr_data = '0; bus_b.wr_valid = 1'b0;
    swap_req = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < DEPTH; i++) begin
        mem_m[b][i] = 8'h00;
        known[b][i] = 1'b0;
      end

    do_reset(3);
    idle(2 * FRAME);                         // raw timing, two frames

    fill_back_bank();                        // bank 1, then show it
    step(0, 0, 0, 8'h00, 1);
    idle(FRAME);
    fill_back_bank();                        // bank 0
    step(1, 10, 5, 8'hAB, 0);
    step(1, 3, 2, 8'hE0, 0);                 // RGB332 pure red
    step(0, 0, 0, 8'h00, 1);
    idle(FRAME + 4);

    // off-screen writes: both must drop without touching memory
    step(1, HA, 0, 8'h55, 0);
    step(1, 0, VA, 8'h66, 0);
    step(0, 0, 0, 8'h00, 1);
    idle(FRAME + 4);

    // three requests inside one frame collapse into one swap
    align(SWAP_OFF + 3);
    acks0 = ack_cnt;
    fs0   = front_sel_a;
    for (int i = 0; i < FRAME; i++)
      step(0, 0, 0, 8'h00, (i == 10) || (i == 150) || (i == 300));
    check("one_ack", ack_cnt - acks0, 1);
    check("toggle_once", front_sel_a, !fs0);

    // random drawing and swapping
    for (int i = 0; i < 6 * FRAME; i++)
      step($urandom_range(0, 1), $urandom_range(0, HA + 3), $urandom_range(0, VA + 1),
           8'($urandom_range(0, 255)), $urandom_range(0, 299) == 0);

    // reset mid-frame with front_sel = 1 and a swap pending
    if (!front_m) begin
      step(0, 0, 0, 8'h00, 1);
      idle(FRAME);
    end
    align(SWAP_OFF + 3);
    step(0, 0, 0, 8'h00, 1);
    idle(60);
    check("pending_before_rst", pend_m, 1'b1);
    do_reset(2);
    acks0 = ack_cnt;
    idle(2 * FRAME);
    check("no_ack_after_rst", ack_cnt - acks0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end
endmodule
